// File: rtl/ddr_cmd_decode.sv
// DDR command decoder: per-bank open/row/tRCD tracking, legality checks and
// burst beat generation with BL-aligned column wrap.
module ddr_cmd_decode #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BL        = 8,
  parameter int TRCD      = 4,
  localparam int BANKGROUPS    = 2**BGWIDTH,
  localparam int BANKSPERGROUP = 2**BAWIDTH,
  localparam int NB            = 2**(BGWIDTH+BAWIDTH)
) (
  input  logic                                                     clk,
  input  logic                                                     reset,
  input  logic                                                     cmd_valid,
  input  logic [2:0]                                               cmd,
  input  logic [BGWIDTH-1:0]                                       bg,
  input  logic [BAWIDTH-1:0]                                       ba,
  input  logic [ADDRWIDTH-1:0]                                     addr,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                 rd_o_wr,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][ADDRWIDTH-1:0]  row,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][COLWIDTH-1:0]   column,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                 beat_valid,
  output logic [NB-1:0]                                            bank_open,
  output logic                                                     busy,
  output logic                                                     cmd_err
);

  localparam int BW   = BGWIDTH + BAWIDTH;
  localparam int CNTW = $clog2(BL + 1);
  localparam int TW   = (TRCD > 1) ? $clog2(TRCD) : 1;
  localparam logic [COLWIDTH-1:0] BL_MASK   = COLWIDTH'(BL - 1);
  localparam logic [TW-1:0]       TRCD_LOAD = TW'(TRCD - 1);
  localparam logic [CNTW-1:0]     LAST_CNT  = CNTW'(BL - 1);

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;
  localparam logic [2:0] CMD_REF  = 3'd6;

  // B_IDLE: no burst | B_RD: read beats | B_WR: write beats
  typedef enum logic [1:0] {B_IDLE, B_RD, B_WR} burst_t;

  burst_t                          state_q, state_d;
  logic [CNTW-1:0]                 cnt_q, cnt_d;
  logic [BW-1:0]                   bank_q, bank_d;
  logic [NB-1:0]                   open_q, open_d;
  logic [NB-1:0][TW-1:0]           trcd_q, trcd_d;
  logic [NB-1:0][ADDRWIDTH-1:0]    row_q, row_d;
  logic [NB-1:0][COLWIDTH-1:0]     col_q, col_d;
  logic [NB-1:0]                   beat_q, beat_d;
  logic [NB-1:0]                   wr_q, wr_d;
  logic                            err_q, err_d;

  logic [BW-1:0] b;
  logic          busy_w, last_beat, legal;
  logic          act_go, rdwr_go, pre_go, prea_go;

  assign b = {bg, ba};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= B_IDLE;
      cnt_q   <= '0;
      bank_q  <= '0;
      open_q  <= '0;
      trcd_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      beat_q  <= '0;
      wr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      open_q  <= open_d;
      trcd_q  <= trcd_d;
      row_q   <= row_d;
      col_q   <= col_d;
      beat_q  <= beat_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    legal = 1'b0;
    case (cmd)
      CMD_NOP:        legal = 1'b1;
      CMD_ACT:        legal = !open_q[b];
      CMD_RD, CMD_WR: legal = open_q[b] && (trcd_q[b] == '0) && (!busy_w || last_beat);
      CMD_PRE:        legal = !(open_q[b] && busy_w && (bank_q == b));
      CMD_PREA:       legal = !busy_w;
      CMD_REF:        legal = (open_q == '0) && !busy_w;
      default:        legal = 1'b0;
    endcase
    act_go  = cmd_valid && legal && (cmd == CMD_ACT);
    rdwr_go = cmd_valid && legal && ((cmd == CMD_RD) || (cmd == CMD_WR));
    pre_go  = cmd_valid && legal && (cmd == CMD_PRE);
    prea_go = cmd_valid && legal && (cmd == CMD_PREA);
    err_d   = cmd_valid && (cmd != CMD_NOP) && !legal;
  end

  // Next-state: a legal RD/WR is only accepted when idle or on the final beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      B_IDLE: if (rdwr_go) state_d = (cmd == CMD_WR) ? B_WR : B_RD;
      default: begin
        if (rdwr_go)        state_d = (cmd == CMD_WR) ? B_WR : B_RD;
        else if (last_beat) state_d = B_IDLE;
      end
    endcase
  end

  always_comb begin
    busy_w    = (state_q != B_IDLE);
    last_beat = busy_w && (cnt_q == LAST_CNT);
    beat_d    = '0;
    wr_d      = '0;
    if (state_d != B_IDLE) begin
      beat_d[bank_d] = 1'b1;
      wr_d[bank_d]   = (state_d == B_WR);
    end
  end

  always_comb begin
    bank_d = rdwr_go ? b : bank_q;
    cnt_d  = '0;
    if (!rdwr_go && busy_w && !last_beat) cnt_d = cnt_q + CNTW'(1);
    col_d = col_q;
    if (rdwr_go)
      col_d[b] = addr[COLWIDTH-1:0];
    else if (busy_w && !last_beat)
      col_d[bank_q] = (col_q[bank_q] & ~BL_MASK) | ((col_q[bank_q] + COLWIDTH'(1)) & BL_MASK);
    open_d = open_q;
    row_d  = row_q;
    for (int i = 0; i < NB; i++)
      trcd_d[i] = (trcd_q[i] != '0) ? trcd_q[i] - TW'(1) : '0;
    if (act_go) begin
      open_d[b] = 1'b1;
      row_d[b]  = addr;
      trcd_d[b] = TRCD_LOAD;
    end
    if (pre_go)  open_d[b] = 1'b0;
    if (prea_go) open_d    = '0;
  end

  assign rd_o_wr    = wr_q;
  assign beat_valid = beat_q;
  assign row        = row_q;
  assign column     = col_q;
  assign bank_open  = open_q;
  assign busy       = busy_w;
  assign cmd_err    = err_q;

endmodule

// File: tb/tb_ddr_cmd_decode.sv
// Scoreboard bench for ddr_cmd_decode: the driver runs a cycle-level command
// model and queues expectations; the monitor compares them at each negedge.
module tb_ddr_cmd_decode;
  localparam int BGWIDTH = 2, BAWIDTH = 2, ADDRWIDTH = 17, COLWIDTH = 10, BL = 8, TRCD = 4;
  localparam int G = 2**BGWIDTH, P = 2**BAWIDTH, NB = G * P;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, cmd_valid = 1'b0;
  logic [2:0] cmd = '0;
  logic [BGWIDTH-1:0] bg = '0;
  logic [BAWIDTH-1:0] ba = '0;
  logic [ADDRWIDTH-1:0] addr = '0;
  logic [G-1:0][P-1:0] rd_o_wr, beat_valid;
  logic [G-1:0][P-1:0][ADDRWIDTH-1:0] row;
  logic [G-1:0][P-1:0][COLWIDTH-1:0] column;
  logic [NB-1:0] bank_open;
  logic busy, cmd_err;

  ddr_cmd_decode #(.BGWIDTH(BGWIDTH), .BAWIDTH(BAWIDTH), .ADDRWIDTH(ADDRWIDTH),
                   .COLWIDTH(COLWIDTH), .BL(BL), .TRCD(TRCD)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .bg(bg), .ba(ba),
    .addr(addr), .rd_o_wr(rd_o_wr), .row(row), .column(column), .beat_valid(beat_valid),
    .bank_open(bank_open), .busy(busy), .cmd_err(cmd_err));

  typedef struct {int cyc; int bank; logic [COLWIDTH-1:0] col; bit wr;} beat_t;
  typedef struct {int cyc; logic [NB-1:0] open; logic [NB-1:0][ADDRWIDTH-1:0] rows; bit zero;} st_t;

  beat_t bq[$];
  int    eq[$];
  st_t   sq[$];

  logic [NB-1:0]                m_open = '0;
  logic [NB-1:0][ADDRWIDTH-1:0] m_row = '0;
  int                           m_act[NB];
  int                           m_last = -1000;
  int                           m_bb = 0;
  logic [NB-1:0][COLWIDTH-1:0]  exp_col = '0;

  int cyc = 0;
  bit mon_en = 1'b0;
  int n_chk = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  // Drive one command cycle and advance the model by the command rules.
  task automatic step(input bit rst, input bit v, input logic [2:0] c, input int bank,
                      input logic [ADDRWIDTH-1:0] a);
    int k;
    bit lg;
    int st;
    beat_t bt;
    k = cyc;
    reset = rst; cmd_valid = v; cmd = c; addr = a;
    bg = BGWIDTH'(bank / P); ba = BAWIDTH'(bank % P);
    if (rst) begin
      m_open = '0; m_row = '0; m_last = -1000;
      for (int i = bq.size() - 1; i >= 0; i--) if (bq[i].cyc > k) bq.delete(i);
      for (int i = eq.size() - 1; i >= 0; i--) if (eq[i] > k) eq.delete(i);
    end else if (v && c != 3'd0) begin
      lg = 1'b1;
      case (c)
        3'd1: if (m_open[bank]) lg = 1'b0;
              else begin m_open[bank] = 1'b1; m_row[bank] = a; m_act[bank] = k; end
        3'd2, 3'd3: begin
          if (!m_open[bank] || (k - m_act[bank]) < TRCD || k < m_last) lg = 1'b0;
          else begin
            st = int'(a[COLWIDTH-1:0]);
            for (int j = 0; j < BL; j++) begin
              bt.cyc = k + 1 + j; bt.bank = bank; bt.wr = (c == 3'd3);
              bt.col = COLWIDTH'((st / BL) * BL + (st % BL + j) % BL);
              bq.push_back(bt);
            end
            m_last = k + BL; m_bb = bank;
          end
        end
        3'd4: if (m_open[bank] && k <= m_last && bank == m_bb) lg = 1'b0;
              else m_open[bank] = 1'b0;
        3'd5: if (k <= m_last) lg = 1'b0; else m_open = '0;
        3'd6: if (m_open != '0 || k <= m_last) lg = 1'b0;
        default: lg = 1'b0;
      endcase
      if (!lg) eq.push_back(k + 1);
    end
    sq.push_back('{k + 1, m_open, m_row, rst});
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] c, input int bank, input logic [ADDRWIDTH-1:0] a);
    step(1'b0, 1'b1, c, bank, a);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 0, '0);
  endtask

  task automatic check_cycle();
    logic [NB-1:0] ebv, ewr;
    bit eb, ee;
    beat_t bt;
    st_t s;
    ebv = '0; ewr = '0;
    while (sq.size() > 0 && sq[0].cyc < cyc) void'(sq.pop_front());
    if (sq.size() > 0 && sq[0].cyc == cyc) begin
      s = sq.pop_front();
      if (s.zero) exp_col = '0;
      chk("bank_open", 512'(bank_open), 512'(s.open));
      chk("row", 512'(row), 512'(s.rows));
    end
    eb = (bq.size() > 0 && bq[0].cyc == cyc);
    if (eb) begin
      bt = bq.pop_front();
      ebv[bt.bank] = 1'b1;
      ewr[bt.bank] = bt.wr;
      exp_col[bt.bank] = bt.col;
    end
    chk("busy", 512'(busy), 512'(eb));
    chk("beat_valid", 512'(beat_valid), 512'(ebv));
    chk("rd_o_wr", 512'(rd_o_wr), 512'(ewr));
    chk("column", 512'(column), 512'(exp_col));
    ee = (eq.size() > 0 && eq[0] == cyc);
    if (ee) void'(eq.pop_front());
    chk("cmd_err", 512'(cmd_err), 512'(ee));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) check_cycle();
    end
  end

  initial begin
    int r, bank;
    logic [2:0] c;
    @(posedge clk); #1;
    step(1'b1, 1'b1, 3'd1, 6, 17'h0ABCD);
    mon_en = 1'b1;
    step(1'b1, 1'b0, 3'd0, 0, '0);
    issue(3'd1, 6, 17'h1ABCD); nop(1);
    issue(3'd1, 3, 17'h00111); nop(1);
    issue(3'd2, 3, 17'h00005);
    issue(3'd1, 6, 17'h00042);
    issue(3'd7, 6, 17'h00000);
    issue(3'd1, 0, 17'h00123); nop(3);
    issue(3'd2, 0, 17'h00005); nop(3);
    issue(3'd4, 0, '0);
    issue(3'd5, 0, '0); nop(4);
    issue(3'd6, 0, '0); nop(1);
    issue(3'd3, 3, 17'h003F8); nop(7);
    issue(3'd3, 3, 17'h00010); nop(9);
    issue(3'd4, 0, '0);
    issue(3'd5, 0, '0);
    issue(3'd6, 0, '0);
    issue(3'd4, 9, '0); nop(2);
    issue(3'd1, 5, 17'h00155); nop(3);
    issue(3'd3, 5, 17'h00020); nop(3);
    step(1'b1, 1'b1, 3'd1, 5, 17'h1FFFF);
    nop(3);
    for (int i = 0; i < 400; i++) begin
      bank = int'($urandom_range(0, 3)) * 3;
      r = int'($urandom_range(0, 15));
      case (r)
        0, 1:       c = 3'd0;
        2, 3, 4:    c = 3'd1;
        5, 6, 7:    c = 3'd2;
        8, 9, 10:   c = 3'd3;
        11, 12:     c = 3'd4;
        13:         c = 3'd5;
        14:         c = 3'd6;
        default:    c = 3'd7;
      endcase
      if ($urandom_range(0, 149) == 0)
        step(1'b1, 1'b1, c, bank, ADDRWIDTH'($urandom));
      else
        step(1'b0, $urandom_range(0, 9) != 0, c, bank, ADDRWIDTH'($urandom));
    end
    nop(BL + 2);
    chk("beats_left", 512'(bq.size()), 512'(0));
    chk("errs_left", 512'(eq.size()), 512'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
